time_set_ctrl: RTL

- Edit-mode controller that sequences HH:MM setting for the watch and alarm datapaths.
- Captures the current watch or alarm value into an edit buffer and steps a digit cursor with nextDigit.
- Increments the selected BCD digit with per-digit wrap on upTime, then commits the buffer with a one-cycle load strobe to the selected target.
- Sits between the push-button inputs and the watch/alarm time registers; also drives the display blink for the digit under edit.

---
 rtl/time_set_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// HH:MM edit-mode controller: captures watch/alarm time into an edit buffer,
// steps a digit cursor, increments BCD digits with wrap, and strobes a commit.
module time_set_ctrl #(
   parameter int unsigned BLINK_DIV = 250
) (
   input  logic        clk,
   input  logic        resetTime,
   input  logic [2:0]  mode,
   input  logic        setValue,
   input  logic        upTime,
   input  logic        nextDigit,
   input  logic [15:0] cur_time,
   input  logic [15:0] cur_alarm,
   output logic [15:0] edit_value,
   output logic [1:0]  cursor,
   output logic        edit_active,
   output logic        blink,
   output logic        load_watch,
   output logic        load_alarm
);

   localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

   state_t        state_q, state_d;
   logic          target_q, target_d;   // 0 = watch, 1 = alarm
   logic          prev_set_q, prev_up_q, prev_next_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   edit_value_d;
   logic [1:0]    cursor_d;
   logic          edit_active_d, blink_d, load_watch_d, load_alarm_d;
   logic          set_press, up_press, next_press;

   assign set_press  = setValue  & ~prev_set_q;
   assign up_press   = upTime    & ~prev_up_q;
   assign next_press = nextDigit & ~prev_next_q;

   // Out-of-range digits (including invalid BCD) wrap straight to 0.
   function automatic logic [15:0] bump(input logic [15:0] v, input logic [1:0] c);
      logic [3:0] ht, ho, mt, mo;
      {ht, ho, mt, mo} = v;
      case (c)
         2'd3:    ht = (ht >= 4'd2) ? 4'd0 : ht + 4'd1;
         2'd2:    ho = (ho >= ((ht < 4'd2) ? 4'd9 : 4'd3)) ? 4'd0 : ho + 4'd1;
         2'd1:    mt = (mt >= 4'd5) ? 4'd0 : mt + 4'd1;
         default: mo = (mo >= 4'd9) ? 4'd0 : mo + 4'd1;
      endcase
      if (ht == 4'd2 && ho > 4'd3) ho = 4'd3;
      return {ht, ho, mt, mo};
   endfunction

   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      edit_value_d  = edit_value;
      cursor_d      = cursor;
      cnt_d         = '0;
      blink_d       = 1'b0;
      edit_active_d = 1'b0;
      load_watch_d  = 1'b0;
      load_alarm_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (set_press && mode[2:1] == 2'b00) begin
               edit_value_d  = mode[0] ? cur_alarm : cur_time;
               target_d      = mode[0];
               cursor_d      = 2'd3;
               state_d       = EDIT;
               edit_active_d = 1'b1;
               blink_d       = 1'b1;
            end
         end
         EDIT: begin
            if (mode != {2'b00, target_q}) begin
               state_d = IDLE;
            end else if (set_press) begin
               state_d      = COMMIT;
               load_watch_d = ~target_q;
               load_alarm_d = target_q;
            end else begin
               edit_active_d = 1'b1;
               // Increment uses the pre-advance cursor when both buttons hit together.
               if (up_press)   edit_value_d = bump(edit_value, cursor);
               if (next_press) cursor_d = cursor - 2'd1;
               if (up_press || next_press) begin
                  blink_d = 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  blink_d = ~blink;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  blink_d = blink;
               end
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetTime) begin
         state_q     <= IDLE;
         target_q    <= 1'b0;
         prev_set_q  <= 1'b1;
         prev_up_q   <= 1'b1;
         prev_next_q <= 1'b1;
         cnt_q       <= '0;
         edit_value  <= '0;
         cursor      <= 2'd3;
         edit_active <= 1'b0;
         blink       <= 1'b0;
         load_watch  <= 1'b0;
         load_alarm  <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         prev_set_q  <= setValue;
         prev_up_q   <= upTime;
         prev_next_q <= nextDigit;
         cnt_q       <= cnt_d;
         edit_value  <= edit_value_d;
         cursor      <= cursor_d;
         edit_active <= edit_active_d;
         blink       <= blink_d;
         load_watch  <= load_watch_d;
         load_alarm  <= load_alarm_d;
      end
   end

endmodule
